// File: rtl/micro_uart_rx.sv
// -----------------------------------------------------------------------------
// micro_uart_rx : micro-tile UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is
// defined), fixed oversampling of CLKS_PER_BIT clocks per serial bit.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   ui_in[0]     rxd      serial line, idle high
//   ui_in[1]     rd_ack   rising edge clears valid and the error flags
//   ui_in[2]     view_sel 0 = received byte, 1 = status byte
//   ui_in[7:3]   unused
//   uo_out       view_sel=0: rx_data
//                view_sel=1: {valid, frame_err, overrun, parity_err, busy, 3'b000}
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit after the
// eighth data bit; without it status bit 4 is constant 0).
// -----------------------------------------------------------------------------
module micro_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  // Input synchronisers
  logic rxd_meta_q, rxd_s_q;
  logic ack_meta_q, ack_s_q, ack_prev_q;
  logic ack_pulse;

  // Receive datapath
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          commit_q, commit_d;
  logic          fe_set;

  // Host-visible registers
  logic [7:0] rx_data_q, rx_data_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       parity_flag;
  logic       busy;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
`endif

  logic unused_pins;
  assign unused_pins = ^ui_in[7:3];

  assign ack_pulse = ack_s_q & ~ack_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      rxd_meta_q <= ui_in[0];
      rxd_s_q    <= rxd_meta_q;
      ack_meta_q <= ui_in[1];
      ack_s_q    <= ack_meta_q;
      ack_prev_q <= ack_s_q;
    end
  end

  // Next-state logic. Sampling happens mid-bit: the start bit is re-checked
  // half a bit after the falling edge, then every full bit period after that.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    commit_d  = 1'b0;
    fe_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line already back high at mid-start-bit was only a glitch.
          state_d   = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) != rxd_s_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            // Leave mid-stop-bit so a back-to-back start edge is not missed.
            commit_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flag update: the acknowledge clear is applied first so a commit or a new
  // framing error in the same cycle survives it.
  always_comb begin
    rx_data_d   = rx_data_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (ack_pulse) begin
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    if (fe_set) frame_err_d = 1'b1;
    if (commit_q) begin
      if (!valid_d) begin
        rx_data_d = shift_q;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (par_bad_q) parity_err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      rx_data_q   <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      rx_data_q   <= rx_data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_flag = parity_err_q;
`else
  assign parity_flag = 1'b0;
`endif

  assign busy   = (state_q != S_IDLE);
  assign uo_out = ui_in[2] ? {valid_q, frame_err_q, overrun_q, parity_flag, busy, 3'b000}
                           : rx_data_q;

endmodule
